// File: rtl/ram_word_port.sv
// ram_word_port: bridges a 32-bit word load/store port to the 128-bit line
// user interface of the `ram` DDR3 controller. Loads fetch a line and return
// the addressed word. Stores read the line, merge the enabled bytes and write
// the line back. Only one access is outstanding at a time.
//
// Optional feature, macro RAM_WORD_PORT_LINE_BUF_EN: a one-line buffer
// (tag = addr[31:4] plus valid bit) filled by every completed line read and
// updated on every completed line write. Load hits finish without `ram`
// traffic; store hits merge into the buffered line and write it through.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   core_req/we/addr/wdata/be   core access request (req held until done)
//   core_done/rdata/err   one-cycle completion pulse with load data / timeout
//   addr_in, write_data_in, read_req, write_req   commands to `ram`
//   read_ready, read_data_valid, read_data_out, write_ready   `ram` responses
module ram_word_port #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         core_req,
  input  logic         core_we,
  input  logic [31:0]  core_addr,
  input  logic [31:0]  core_wdata,
  input  logic [3:0]   core_be,
  output logic         core_done,
  output logic [31:0]  core_rdata,
  output logic         core_err,
  output logic [31:0]  addr_in,
  output logic [127:0] write_data_in,
  output logic         read_req,
  output logic         write_req,
  input  logic         read_ready,
  input  logic         read_data_valid,
  input  logic [127:0] read_data_out,
  input  logic         write_ready
);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StMerge,
    StWrReq,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_in_q, addr_in_d;
  logic [1:0]      ws_q, ws_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [127:0]    line_q, line_d;
  logic [127:0]    wr_line_q, wr_line_d;
  logic            err_q, err_d;
  logic [127:0]    merged;
  logic            timeout;

`ifdef RAM_WORD_PORT_LINE_BUF_EN
  logic            buf_valid_q, buf_valid_d;
  logic [27:0]     buf_tag_q, buf_tag_d;
  logic [127:0]    buf_line_q, buf_line_d;
  logic            buf_hit;
  assign buf_hit = buf_valid_q && (buf_tag_q == core_addr[31:4]);
`endif

  // Address bits [1:0] are don't-care for word accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^core_addr[1:0];

  // Last waiting cycle: the wait lasts exactly TIMEOUT_CYCLES cycles.
  assign timeout = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Byte merge of the store word into the addressed word of the line.
  always_comb begin
    merged = line_q;
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) begin
        merged[{ws_q, b[1:0], 3'd0} +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_in_d = addr_in_q;
    ws_d      = ws_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    line_d    = line_q;
    wr_line_d = wr_line_q;
    err_d     = err_q;
`ifdef RAM_WORD_PORT_LINE_BUF_EN
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_line_d  = buf_line_q;
`endif

    unique case (state_q)
      StIdle: begin
        err_d = 1'b0;
        if (core_req) begin
          addr_in_d = {core_addr[31:4], 4'h0};
          ws_d      = core_addr[3:2];
          we_d      = core_we;
          wdata_d   = core_wdata;
          be_d      = core_be;
          cnt_d     = '0;
          state_d   = StRdReq;
`ifdef RAM_WORD_PORT_LINE_BUF_EN
          if (buf_hit) begin
            line_d  = buf_line_q;
            state_d = core_we ? StMerge : StDone;
          end
`endif
        end
      end

      StRdReq: begin
        if (read_ready) begin
          cnt_d = '0;
          if (read_data_valid) begin
            line_d  = read_data_out;
            state_d = we_q ? StMerge : StDone;
`ifdef RAM_WORD_PORT_LINE_BUF_EN
            buf_valid_d = 1'b1;
            buf_tag_d   = addr_in_q[31:4];
            buf_line_d  = read_data_out;
`endif
          end else begin
            state_d = StRdWait;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
`ifdef RAM_WORD_PORT_LINE_BUF_EN
          buf_valid_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StRdWait: begin
        if (read_data_valid) begin
          line_d  = read_data_out;
          state_d = we_q ? StMerge : StDone;
`ifdef RAM_WORD_PORT_LINE_BUF_EN
          buf_valid_d = 1'b1;
          buf_tag_d   = addr_in_q[31:4];
          buf_line_d  = read_data_out;
`endif
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
`ifdef RAM_WORD_PORT_LINE_BUF_EN
          buf_valid_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StMerge: begin
        line_d    = merged;
        wr_line_d = merged;
        cnt_d     = '0;
        state_d   = StWrReq;
      end

      StWrReq: begin
        if (write_ready) begin
          state_d = StDone;
`ifdef RAM_WORD_PORT_LINE_BUF_EN
          buf_valid_d = 1'b1;
          buf_tag_d   = addr_in_q[31:4];
          buf_line_d  = wr_line_q;
`endif
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
`ifdef RAM_WORD_PORT_LINE_BUF_EN
          buf_valid_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_in_q <= '0;
      ws_q      <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      line_q    <= '0;
      wr_line_q <= '0;
      err_q     <= 1'b0;
`ifdef RAM_WORD_PORT_LINE_BUF_EN
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_line_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_in_q <= addr_in_d;
      ws_q      <= ws_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      line_q    <= line_d;
      wr_line_q <= wr_line_d;
      err_q     <= err_d;
`ifdef RAM_WORD_PORT_LINE_BUF_EN
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_line_q  <= buf_line_d;
`endif
    end
  end

  // Requests and completion are decoded from the registered state, so they
  // drop on the edge that leaves the state (including reset).
  assign read_req      = (state_q == StRdReq);
  assign write_req     = (state_q == StWrReq);
  assign core_done     = (state_q == StDone);
  assign core_err      = core_done && err_q;
  assign core_rdata    = (core_done && !we_q && !err_q) ? line_q[{ws_q, 5'd0} +: 32] : 32'h0;
  assign addr_in       = addr_in_q;
  assign write_data_in = wr_line_q;

endmodule

// File: doc/ram_word_port.md
Name: ram_word_port

Overview:
- Bridges the core's 32-bit word load/store port to the 128-bit line user interface of the `ram` DDR3 controller.
- Acts as the initiator on the `ram` user interface.
- Loads read one line and return the selected word.
- Stores perform read-modify-write: read the line, merge the enabled bytes, write the line back.
- Sits between the core's data-memory port and `ram`.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles waiting on any single `ram` handshake before aborting with an error.
- TO_W, 11: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- core_req  in  1  access request; held high until core_done.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  32  byte address; bits [1:0] ignored.
- core_wdata  in  32  store data.
- core_be  in  4  store byte enables.
- core_done  out  1  one-cycle completion pulse.
- core_rdata  out  32  load data; valid while core_done is high.
- core_err  out  1  timeout flag; valid while core_done is high.
- addr_in  out  32  line address to `ram`: {core_addr[31:4],4'h0}.
- write_data_in  out  128  line to write.
- read_req  out  1  read request to `ram`.
- write_req  out  1  write request to `ram`.
- read_ready  in  1  `ram` accepted the read command.
- read_data_valid  in  1  one-cycle pulse: read_data_out is valid.
- read_data_out  in  128  read line data.
- write_ready  in  1  `ram` completed the write.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): FSM goes to IDLE. All outputs go to 0: core_done, core_err, core_rdata, read_req, write_req, addr_in, write_data_in. Timeout counter cleared. Reset mid-transaction aborts immediately: req lines drop on the next edge and no core_done is issued.
- Word select: ws = core_addr[3:2]. Word k occupies line bits [32k+31:32k]; word 0 is the LSW.
- FSM states: IDLE, RD_REQ, RD_WAIT, MERGE, WR_REQ, DONE.
- IDLE: on core_req=1, latch addr, we, wdata, be and ws; drive addr_in; assert read_req next cycle; go to RD_REQ. A core store with be=4'h0 still performs the full RMW.
- RD_REQ: hold read_req=1 until read_ready=1. Drop read_req on the cycle after read_ready is seen, then go to RD_WAIT. If read_data_valid arrives in the same cycle as read_ready, capture the data and go directly to MERGE (loads go to DONE).
- RD_WAIT: on read_data_valid=1, capture read_data_out into the line register.
  - Load: go to DONE.
  - Store: go to MERGE.
- MERGE (1 cycle): for each byte b with be[b]=1, replace line byte (4*ws+b) with wdata byte b. Drive write_data_in; set write_req=1; go to WR_REQ.
- WR_REQ: hold write_req and write_data_in stable until write_ready=1. Drop write_req the next cycle; go to DONE.
- DONE: core_done=1 for exactly one cycle; core_rdata = line word ws for loads (0 for stores); core_err=0; return to IDLE. A new request can be accepted the cycle after DONE.
- Timing: a load completes in 3 cycles plus the `ram` latency. No overlap between transactions: one outstanding access maximum.
- read_req and write_req are never asserted simultaneously.
- Timeout:
  - The counter resets on each entry to RD_REQ, RD_WAIT or WR_REQ and increments each cycle while waiting there.
  - At TIMEOUT_CYCLES: drop any req, go to DONE with core_err=1 and core_rdata=0.
  - A late read_data_valid or write_ready from `ram` arriving while IDLE is ignored.
- Spurious handshakes: read_ready, read_data_valid or write_ready in a state that does not expect them are ignored.
- core_req deasserted mid-transaction: the transaction still completes and core_done is still pulsed.

Optional Feature:
- Macro: RAM_WORD_PORT_LINE_BUF_EN.
- Defined: adds a one-line buffer (tag = addr[31:4] plus valid bit).
  - Filled by every completed memory read; updated with the merged line on every completed write.
  - Load hit in IDLE: goes straight to DONE (core_done 2 cycles after core_req), with no `ram` traffic.
  - Store hit: skips RD_REQ/RD_WAIT and merges into the buffered line (write-through).
  - The valid bit is cleared on rst and on any timeout.
- Undefined: no buffer; every access goes through `ram`.

Test Plan:
- Load, no buffer: `ram` line 0x1000 = 128'h44444444_33333333_22222222_11111111; load addr 0x1008 -> exactly one read_req handshake, addr_in=0x1000, core_rdata=0x33333333, core_err=0, no write_req.
- Store RMW: same line; store addr 0x1004, wdata 0xDEADBEEF, be=4'b0101 -> write_data_in=128'h44444444_33333333_22AD22EF_11111111; single write_req; core_done one cycle.
- Timeout: `ram` never asserts read_ready; load 0x2000 -> read_req held TIMEOUT_CYCLES cycles, then dropped; core_done=1, core_err=1, core_rdata=0. A later read_data_valid is ignored.
- Reset mid-write: assert rst while in WR_REQ -> write_req=0 and all outputs 0 next cycle, no core_done; the next load runs normally.
- Same-cycle ready and data: read_ready and read_data_valid together with 128'hA5 pattern, load addr 0x0 -> correct word returned, no stall in RD_WAIT.
- LINE_BUF_EN: load 0x1000 then load 0x100C -> second load produces no read_req, core_rdata=0x44444444, done 2 cycles after request. Then store to 0x100C -> write_req only, no read_req.
